// File: rtl/jtpopeye_dma_ctrl.sv
// jtpopeye_dma_ctrl
// Object-RAM DMA engine for the Popeye video board. Each rising edge of VB
// requests the Z80 bus and copies one LEN-byte burst from main RAM into the
// four object-RAM banks, moving one byte every four pxl_cen ticks.
//
// Parameters
//   LEN      bytes per burst (4..1024)
//   TOUT     bus-request timeout in pxl_cen ticks (timeout build only)
//
// Ports
//   clk       in   sole clock, rising edge
//   rst       in   synchronous, active-high reset
//   pxl_cen   in   pixel clock enable
//   VB        in   vertical blank
//   H[1:0]    in   pixel phase, steps 00,01,10,11 on pxl_cen
//   busak_n   in   Z80 bus acknowledge, active low
//   busrq_n   out  Z80 bus request, active low
//   dma_cs    out  main-RAM read enable
//   dma_addr  out  byte index within the burst
//   dma_we    out  one-hot write strobe, bank = dma_addr[9:8]
//   busy      out  engine not idle
//   done      out  one-clk pulse after the final write
//   overrun   out  sticky: VB rose while a burst was still in progress
//   tout_err  out  sticky: bus request timed out
//
// Build option
//   JTPOPEYE_DMA_TIMEOUT_EN  when defined, REQ gives up after TOUT ticks
//                            without a bus acknowledge; otherwise REQ waits
//                            forever and tout_err is tied low.

module jtpopeye_dma_ctrl #(
  parameter int LEN  = 1024,
  parameter int TOUT = 4095
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pxl_cen,
  input  logic       VB,
  input  logic [1:0] H,
  input  logic       busak_n,
  output logic       busrq_n,
  output logic       dma_cs,
  output logic [9:0] dma_addr,
  output logic [3:0] dma_we,
  output logic       busy,
  output logic       done,
  output logic       overrun,
  output logic       tout_err
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    REL
  } state_t;

  localparam logic [9:0] LAST = 10'(LEN - 1);

  state_t state;
  state_t state_nx;

  logic vb_q;
  logic vb_rise;
  logic cs_q;
  logic inc_pend;
  logic wr_tick;
  logic last_wr;
  logic tout_hit;

  // VB edge detection runs every clk, not only on pxl_cen ticks.
  assign vb_rise = VB & ~vb_q;

  assign wr_tick = (state == XFER) && cs_q && pxl_cen && (H == 2'b11);
  assign last_wr = wr_tick && (dma_addr == LAST);

`ifdef JTPOPEYE_DMA_TIMEOUT_EN
  localparam logic [11:0] TOUT_CNT = 12'(TOUT);

  logic [11:0] tcnt;

  assign tout_hit = (state == REQ) && busak_n && (tcnt == TOUT_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt     <= '0;
      tout_err <= 1'b0;
    end else begin
      if (state == IDLE && vb_rise) begin
        tcnt <= '0;
      end else if (state == REQ && pxl_cen && tcnt != '1) begin
        tcnt <= tcnt + 12'd1;
      end
      if (tout_hit) begin
        tout_err <= 1'b1;
      end
    end
  end
`else
  assign tout_hit = 1'b0;
  assign tout_err = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_nx = state;
    busrq_n  = 1'b1;
    busy     = 1'b1;
    dma_cs   = cs_q;
    dma_we   = '0;

    case (state)
      IDLE: begin
        busy = 1'b0;
        if (vb_rise) begin
          state_nx = REQ;
        end
      end
      REQ: begin
        busrq_n = 1'b0;
        if (tout_hit) begin
          state_nx = IDLE;
        end else if (pxl_cen && H == 2'b01 && !busak_n) begin
          state_nx = XFER;
        end
      end
      XFER: begin
        busrq_n = 1'b0;
        if (last_wr) begin
          state_nx = REL;
        end
      end
      REL: begin
        // A VB rise coinciding with this exit is flagged as an overrun
        // below and, being consumed here, never starts a new burst.
        if (pxl_cen && busak_n) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    // Strobe is combinational so it lasts exactly the tick clk and can
    // never be seen outside XFER, even on the final byte.
    if (wr_tick) begin
      dma_we[dma_addr[9:8]] = 1'b1;
    end
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      vb_q     <= VB;
      cs_q     <= 1'b0;
      inc_pend <= 1'b0;
      dma_addr <= '0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      vb_q <= VB;
      done <= last_wr;

      if (vb_rise && state != IDLE) begin
        overrun <= 1'b1;
      end

      case (state)
        IDLE: begin
          cs_q     <= 1'b0;
          inc_pend <= 1'b0;
          if (vb_rise) begin
            dma_addr <= '0;
          end
        end
        REQ: begin
          // Entry happens on an H=01 tick with busak_n low, which is
          // exactly the sample dma_cs would take on that tick.
          if (state_nx == XFER) begin
            cs_q <= 1'b1;
          end
        end
        XFER: begin
          if (pxl_cen) begin
            if (H == 2'b01) begin
              cs_q <= ~busak_n;
            end
            // Increment lands on the tick after the write; it is not
            // gated by cs_q, so a pause never splits a byte.
            if (inc_pend) begin
              dma_addr <= dma_addr + 10'd1;
              inc_pend <= 1'b0;
            end
            if (wr_tick && !last_wr) begin
              inc_pend <= 1'b1;
            end
            if (last_wr) begin
              cs_q <= 1'b0;
            end
          end
        end
        REL: begin
          cs_q     <= 1'b0;
          inc_pend <= 1'b0;
        end
        default: begin
          cs_q     <= 1'b0;
          inc_pend <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtpopeye_dma_ctrl.sv
module tb_jtpopeye_dma_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pxl_cen = 1'b0;
  logic       VB = 1'b0;
  logic [1:0] H = 2'b00;
  logic       busak_n = 1'b1;
  logic       busrq_n;
  logic       dma_cs;
  logic [9:0] dma_addr;
  logic [3:0] dma_we;
  logic       busy;
  logic       done;
  logic       overrun;
  logic       tout_err;

  // Bus model controls (written by the stimulus process only)
  logic       auto_ack = 1'b0;
  logic       force_hi = 1'b0;
  logic [2:0] ack_sh = 3'b000;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  int bank_cnt [4] = '{0, 0, 0, 0};
  bit stall = 1'b0;
  logic [9:0] exp_q [$];

  jtpopeye_dma_ctrl #(.LEN(1024), .TOUT(4095)) dut (
    .clk      (clk),
    .rst      (rst),
    .pxl_cen  (pxl_cen),
    .VB       (VB),
    .H        (H),
    .busak_n  (busak_n),
    .busrq_n  (busrq_n),
    .dma_cs   (dma_cs),
    .dma_addr (dma_addr),
    .dma_we   (dma_we),
    .busy     (busy),
    .done     (done),
    .overrun  (overrun),
    .tout_err (tout_err)
  );

  always #5 clk = ~clk;

  // pxl_cen every other clk; H advances after each tick; busak_n follows
  // busrq_n delayed by three pxl_cen ticks when auto_ack is set.
  always @(posedge clk) begin
    #1;
    if (pxl_cen) begin
      H      = H + 2'd1;
      ack_sh = {ack_sh[1:0], ~busrq_n};
    end
    pxl_cen = ~pxl_cen;
    busak_n = force_hi ? 1'b1 : (auto_ack ? ~ack_sh[2] : 1'b1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_burst();
    for (int unsigned i = 0; i < 1024; i++) exp_q.push_back(10'(i));
  endtask

  task automatic wait_done(input string tag);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < 20000) begin
      step();
      n++;
    end
    chk(tag, done_cnt - d0, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      step();
      n++;
    end
    chk(tag, busy, 0);
  endtask

  task automatic wait_addr(input string tag, input logic [9:0] a);
    int n;
    n = 0;
    while (dma_addr !== a && n < 10000) begin
      step();
      n++;
    end
    chk(tag, dma_addr, a);
  endtask

  initial begin
    int base;
    int dbase;
    int w0;
    int n;

    // Write monitor and scoreboard consumer
    fork
      forever begin
        @(negedge clk);
        if (dma_we !== 4'b0000) begin
          wr_cnt++;
          for (int i = 0; i < 4; i++) if (dma_we[i] === 1'b1) bank_cnt[i]++;
          if (stall) chk("stall_wr", dma_we, 0);
          if (exp_q.size() == 0) begin
            chk("unexpected_wr", exp_q.size(), 1);
          end else begin
            logic [9:0] e;
            e = exp_q.pop_front();
            chk("wr_addr", dma_addr, e);
            chk("wr_strobe", dma_we, 32'(4'b0001 << e[9:8]));
            chk("wr_cs", dma_cs, 1);
          end
        end
        if (done === 1'b1) done_cnt++;
      end
    join_none

    // Reset state
    repeat (4) step();
    chk("rst_busrq_n", busrq_n, 1);
    chk("rst_dma_cs", dma_cs, 0);
    chk("rst_dma_we", dma_we, 0);
    chk("rst_dma_addr", dma_addr, 0);
    chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_tout_err", tout_err, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    repeat (4) step();

    // Full burst with acknowledge tracking the request
    auto_ack = 1'b1;
    push_burst();
    VB = 1'b1;
    step();
    chk("t1_req_busrq_n", busrq_n, 0);
    chk("t1_req_addr", dma_addr, 0);
    chk("t1_req_busy", busy, 1);
    wait_done("t1_done");
    chk("t1_busrq_after_last", busrq_n, 1);
    chk("t1_cs_after_last", dma_cs, 0);
    chk("t1_addr_hold", dma_addr, 1023);
    chk("t1_writes", wr_cnt, 1024);
    for (int i = 0; i < 4; i++) chk("t1_bank_writes", bank_cnt[i], 256);
    wait_idle("t1_idle");
    chk("t1_idle_addr", dma_addr, 1023);
    chk("t1_done_once", done_cnt, 1);
    chk("t1_queue_empty", exp_q.size(), 0);
    chk("t1_overrun", overrun, 0);
    VB = 1'b0;
    repeat (4) step();

    // Bus pause at byte 300
    base = wr_cnt;
    dbase = done_cnt;
    push_burst();
    VB = 1'b1;
    step();
    wait_addr("t2_reach_300", 10'd300);
    force_hi = 1'b1;
    n = 0;
    while (dma_cs !== 1'b0 && n < 20) begin
      step();
      n++;
    end
    chk("t2_cs_drop", dma_cs, 0);
    chk("t2_addr_at_pause", dma_addr, 300);
    stall = 1'b1;
    w0 = wr_cnt;
    repeat (80) step();
    chk("t2_no_wr_in_stall", wr_cnt - w0, 0);
    chk("t2_addr_held", dma_addr, 300);
    chk("t2_still_requesting", busrq_n, 0);
    stall = 1'b0;
    force_hi = 1'b0;
    wait_done("t2_done");
    chk("t2_writes", wr_cnt - base, 1024);
    wait_idle("t2_idle");
    chk("t2_done_once", done_cnt - dbase, 1);
    VB = 1'b0;
    repeat (4) step();

    // Second VB rise mid-transfer
    base = wr_cnt;
    dbase = done_cnt;
    push_burst();
    VB = 1'b1;
    repeat (6) step();
    VB = 1'b0;
    wait_addr("t3_reach_100", 10'd100);
    VB = 1'b1;
    repeat (2) step();
    chk("t3_overrun", overrun, 1);
    chk("t3_still_busy", busrq_n, 0);
    wait_done("t3_done");
    chk("t3_writes", wr_cnt - base, 1024);
    wait_idle("t3_idle");
    chk("t3_done_once", done_cnt - dbase, 1);
    chk("t3_overrun_sticky", overrun, 1);
    VB = 1'b0;
    repeat (4) step();

    // Reset mid-burst at byte 512
    push_burst();
    VB = 1'b1;
    step();
    wait_addr("t4_reach_512", 10'd512);
    rst = 1'b1;
    step();
    chk("t4_rst_busrq_n", busrq_n, 1);
    chk("t4_rst_cs", dma_cs, 0);
    chk("t4_rst_addr", dma_addr, 0);
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_overrun", overrun, 0);
    rst = 1'b0;
    VB = 1'b0;
    exp_q.delete();
    repeat (20) step();
    base = wr_cnt;
    push_burst();
    VB = 1'b1;
    step();
    chk("t4_fresh_addr", dma_addr, 0);
    chk("t4_fresh_busrq_n", busrq_n, 0);
    wait_done("t4_done");
    chk("t4_writes", wr_cnt - base, 1024);
    wait_idle("t4_idle");
    VB = 1'b0;
    repeat (4) step();

    // VB already high when reset is released
    VB = 1'b1;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (40) step();
    chk("t5_no_start_busy", busy, 0);
    chk("t5_no_start_busrq_n", busrq_n, 1);
    auto_ack = 1'b0;
    VB = 1'b0;
    repeat (2) step();
    VB = 1'b1;
    step();
    chk("t5_start_busy", busy, 1);
    chk("t5_start_busrq_n", busrq_n, 0);

    // No acknowledge at all
    base = wr_cnt;
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
    repeat (8300) step();
    chk("t6_tout_busrq_n", busrq_n, 1);
    chk("t6_tout_err", tout_err, 1);
    chk("t6_tout_idle", busy, 0);
`else
    repeat (400) step();
    chk("t6_wait_busrq_n", busrq_n, 0);
    chk("t6_wait_tout_err", tout_err, 0);
    chk("t6_wait_busy", busy, 1);
`endif
    chk("t6_no_writes", wr_cnt - base, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
